// File: rtl/riffa_axis_pkg.sv
// Shared definitions for the RIFFA RX -> AXI4-Stream image path.
package riffa_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_RX   = 2'd2,
        ST_TX   = 2'd3
    } r2a_state_e;

    // Ratios for the default 128-bit RIFFA / 8-bit pixel build.
    localparam int unsigned PIX_PER_WORD     = 128 / 8;
    localparam int unsigned WORDS32_PER_BEAT = 128 / 32;

    // Same ratios for arbitrary widths, used by parameterised instances.
    function automatic int unsigned pix_per_word(input int unsigned pcie_w, input int unsigned axis_w);
        return pcie_w / axis_w;
    endfunction

    function automatic int unsigned words32_per_beat(input int unsigned pcie_w);
        return pcie_w / 32;
    endfunction

endpackage

// File: rtl/bram_axis_skid.sv
// Two-entry skid buffer behind a 1-cycle-latency BRAM read port.
// rd_i marks a read issued this cycle; its data arrives on rdata_i next cycle.
// credit_o says a read issued now is guaranteed a slot when its data lands.
module bram_axis_skid #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          rd_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          tready_i,
    output logic          tvalid_o,
    output logic [DW-1:0] tdata_o,
    output logic          credit_o
);

    logic          v1_q;
    logic [1:0]    cnt_q;
    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic          push;
    logic          pop;
    logic [2:0]    occ;

    assign tvalid_o = (cnt_q != 2'd0);
    assign tdata_o  = head_q;
    assign push     = v1_q;
    assign pop      = tvalid_o & tready_i;
    // Occupancy after this cycle, counting the read already in flight.
    assign occ      = {1'b0, cnt_q} + {2'b00, v1_q} - {2'b00, pop};
    assign credit_o = (occ < 3'd2);

    // Track the in-flight read and shift data through head/tail entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (clr_i) begin
            v1_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            v1_q <= rd_i;
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= rdata_i;
                    else               tail_q <= rdata_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= rdata_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/riffa_rx_to_axis.sv
// RIFFA RX channel -> BRAM -> AXI4-Stream video replay.
// Optional length check enabled by defining R2A_LEN_CHECK_EN.
module riffa_rx_to_axis
    import riffa_axis_pkg::*;
#(
    parameter int PCIE_DATA_WIDTH = 128,
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int PCIE_ADDR_WIDTH = 12,
    parameter int AXIS_ADDR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  rows,
    input  logic [31:0]                  cols,
    input  logic                         CHNL_RX,
    output logic                         CHNL_RX_ACK,
    input  logic                         CHNL_RX_LAST,
    input  logic [31:0]                  CHNL_RX_LEN,
    input  logic [30:0]                  CHNL_RX_OFF,
    input  logic [PCIE_DATA_WIDTH-1:0]   CHNL_RX_DATA,
    input  logic                         CHNL_RX_DATA_VALID,
    output logic                         CHNL_RX_DATA_REN,
    output logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY,
    output logic                         M_AXIS_TUSER,
    output logic                         M_AXIS_TLAST,
    output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic [PCIE_ADDR_WIDTH-1:0]   addra,
    output logic                         clka,
    output logic [PCIE_DATA_WIDTH-1:0]   dina,
    output logic                         wea,
    output logic [AXIS_ADDR_WIDTH-1:0]   addrb,
    output logic                         clkb,
    input  logic [AXIS_DATA_WIDTH-1:0]   doutb,
    output logic                         enb,
    output logic                         err
);

    localparam int unsigned W32 = words32_per_beat(PCIE_DATA_WIDTH);

    r2a_state_e                 state_q, state_d;
    logic                       ack_q, ack_d;
    logic                       ren_q, ren_d;
    logic [PCIE_ADDR_WIDTH-1:0] addra_q, addra_d;
    logic                       full_q, full_d;
    logic [31:0]                wcnt_q, wcnt_d;
    logic [31:0]                len_q, len_d;
    logic [31:0]                cols_q, cols_d;
    logic [31:0]                npix_q, npix_d;
    logic [31:0]                iss_q, iss_d;
    logic [31:0]                opix_q, opix_d;
    logic [31:0]                ocol_q, ocol_d;

    logic rx_acc, pop, credit, tvalid, enb_c, last_beat;
    logic unused_ok;

    assign unused_ok = ^{CHNL_RX_LAST, CHNL_RX_OFF};

`ifdef R2A_LEN_CHECK_EN
    logic        err_q, err_d, skip_q, skip_d;
    logic [63:0] need_bits, need_words;
    assign need_bits  = 64'(npix_q) * 64'(AXIS_DATA_WIDTH);
    assign need_words = (need_bits + 64'd31) >> 5;
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

    assign clka          = clk;
    assign clkb          = clk;
    assign dina          = CHNL_RX_DATA;
    assign CHNL_RX_ACK   = ack_q;
    assign CHNL_RX_DATA_REN = ren_q;
    assign addra         = addra_q;
    assign addrb         = iss_q[AXIS_ADDR_WIDTH-1:0];
    assign M_AXIS_TKEEP  = '1;
    assign M_AXIS_TSTRB  = '1;

    assign rx_acc    = CHNL_RX_DATA_VALID & ren_q;
    assign wea       = rx_acc & ~full_q;
    assign pop       = tvalid & M_AXIS_TREADY;
    // Read enable is combinational so the first read goes out on the first
    // TX cycle; that is what yields TVALID two cycles after entering TX.
    assign enb_c     = (state_q == ST_TX) && (iss_q < npix_q) && credit;
    assign enb       = enb_c;
    assign last_beat = pop && (opix_q == npix_q - 32'd1);

    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TUSER  = tvalid && (opix_q == 32'd0);
    assign M_AXIS_TLAST  = tvalid && (ocol_q == cols_q - 32'd1);

    bram_axis_skid #(.DW(AXIS_DATA_WIDTH)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != ST_TX),
        .rd_i     (enb_c),
        .rdata_i  (doutb),
        .tready_i (M_AXIS_TREADY),
        .tvalid_o (tvalid),
        .tdata_o  (M_AXIS_TDATA),
        .credit_o (credit)
    );

    // Next-state and register updates for the IDLE/ACK/RX/TX sequence.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        ren_d   = ren_q;
        addra_d = addra_q;
        full_d  = full_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        cols_d  = cols_q;
        npix_d  = npix_q;
        iss_d   = iss_q;
        opix_d  = opix_q;
        ocol_d  = ocol_q;
`ifdef R2A_LEN_CHECK_EN
        err_d   = err_q;
        skip_d  = skip_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (CHNL_RX) begin
                    len_d   = CHNL_RX_LEN;
                    cols_d  = cols;
                    npix_d  = rows * cols;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ren_d   = 1'b1;
                addra_d = '0;
                full_d  = 1'b0;
                wcnt_d  = '0;
                state_d = ST_RX;
`ifdef R2A_LEN_CHECK_EN
                skip_d  = 1'b0;
                if ({32'd0, len_q} != need_words) begin
                    err_d  = 1'b1;
                    skip_d = 1'b1;
                end
`endif
            end
            ST_RX: begin
                if (rx_acc) wcnt_d = wcnt_q + 32'(W32);
                if (wea) begin
                    if (addra_q == '1) full_d = 1'b1;
                    else               addra_d = addra_q + 1'b1;
                end
                // Exit decision uses the updated count so REN drops right
                // after the last word instead of one cycle late.
                if ((wcnt_d >= len_q) || (!CHNL_RX && !CHNL_RX_DATA_VALID)) begin
                    ren_d   = 1'b0;
                    iss_d   = '0;
                    opix_d  = '0;
                    ocol_d  = '0;
                    state_d = ST_TX;
`ifdef R2A_LEN_CHECK_EN
                    if (skip_q) state_d = ST_IDLE;
`endif
                end
            end
            ST_TX: begin
                if (enb_c) iss_d = iss_q + 32'd1;
                if (pop) begin
                    opix_d = opix_q + 32'd1;
                    ocol_d = (ocol_q == cols_q - 32'd1) ? 32'd0 : ocol_q + 32'd1;
                end
                if ((npix_q == 32'd0) || last_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            ren_q   <= 1'b0;
            addra_q <= '0;
            full_q  <= 1'b0;
            wcnt_q  <= '0;
            len_q   <= '0;
            cols_q  <= '0;
            npix_q  <= '0;
            iss_q   <= '0;
            opix_q  <= '0;
            ocol_q  <= '0;
`ifdef R2A_LEN_CHECK_EN
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            ren_q   <= ren_d;
            addra_q <= addra_d;
            full_q  <= full_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            cols_q  <= cols_d;
            npix_q  <= npix_d;
            iss_q   <= iss_d;
            opix_q  <= opix_d;
            ocol_q  <= ocol_d;
`ifdef R2A_LEN_CHECK_EN
            err_q   <= err_d;
            skip_q  <= skip_d;
`endif
        end
    end

endmodule

// File: tb/tb_riffa_rx_to_axis.sv
// Directed bench for riffa_rx_to_axis with a behavioural asymmetric BRAM.
module tb_riffa_rx_to_axis;

    localparam int PW    = 128;
    localparam int AW    = 8;
    localparam int LANES = PW / AW;
`ifdef R2A_LEN_CHECK_EN
    localparam int A_LEN = 2;
`else
    localparam int A_LEN = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   rows, cols;
    logic          CHNL_RX, CHNL_RX_ACK, CHNL_RX_LAST;
    logic [31:0]   CHNL_RX_LEN;
    logic [30:0]   CHNL_RX_OFF;
    logic [PW-1:0] CHNL_RX_DATA;
    logic          CHNL_RX_DATA_VALID, CHNL_RX_DATA_REN;
    logic [AW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TUSER, M_AXIS_TLAST;
    logic [0:0]    M_AXIS_TKEEP, M_AXIS_TSTRB;
    logic [11:0]   addra;
    logic          clka, wea, clkb, enb, err;
    logic [PW-1:0] dina;
    logic [15:0]   addrb;
    logic [AW-1:0] doutb;

    riffa_rx_to_axis #(
        .PCIE_DATA_WIDTH(PW), .AXIS_DATA_WIDTH(AW),
        .PCIE_ADDR_WIDTH(12), .AXIS_ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols),
        .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST),
        .CHNL_RX_LEN(CHNL_RX_LEN), .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
        .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TSTRB(M_AXIS_TSTRB),
        .addra(addra), .clka(clka), .dina(dina), .wea(wea),
        .addrb(addrb), .clkb(clkb), .doutb(doutb), .enb(enb), .err(err)
    );

    always #5 clk = ~clk;

    // Asymmetric BRAM: wide write port, pixel-wide read port, 1-cycle latency.
    logic [AW-1:0] mem [0:65535];
    initial for (int i = 0; i < 65536; i++) mem[i] = '0;
    always @(posedge clka) if (wea) for (int i = 0; i < LANES; i++) mem[int'(addra) * LANES + i] <= dina[i*AW +: AW];
    always @(posedge clkb) if (enb) doutb <= mem[addrb];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor state.
    int          cyc = 0;
    int          ack_cycles, ren_cnt, wea_cnt, stall_cnt, last_cons_cyc, first_tv_cyc;
    logic [9:0]  beat_q[$];
    int          beat_cyc[$];
    logic [11:0] wea_addr[$];
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_beat, cur;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (CHNL_RX_ACK) ack_cycles++;
            if (wea) begin wea_cnt++; wea_addr.push_back(addra); end
            if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) begin ren_cnt++; last_cons_cyc = cyc; end
            cur = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
            if (prev_stall) begin
                check("hold_tvalid", M_AXIS_TVALID, 1);
                check("hold_beat", cur, prev_beat);
            end
            if (M_AXIS_TVALID) begin
                if (first_tv_cyc < 0) first_tv_cyc = cyc;
                if (M_AXIS_TREADY) begin beat_q.push_back(cur); beat_cyc.push_back(cyc); end
                else stall_cnt++;
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_beat  = cur;
        end
    end

    // TREADY driver: always-ready, or a repeating 1,0,0,1,0,1 pattern.
    logic tready_mode = 1'b0;
    bit   pat [6] = '{1, 0, 0, 1, 0, 1};
    initial begin
        int pidx = 0;
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tready_mode) begin
                M_AXIS_TREADY = pat[pidx];
                pidx = (pidx + 1) % 6;
            end else begin
                M_AXIS_TREADY = 1'b1;
            end
        end
    end

    task automatic clear_stats();
        beat_q.delete(); beat_cyc.delete(); wea_addr.delete();
        ack_cycles = 0; ren_cnt = 0; wea_cnt = 0; stall_cnt = 0;
        last_cons_cyc = 0; first_tv_cyc = -1;
    endtask

    task automatic send_frame(input int r, input int c, input int len, input int nbeats,
                              input int gap, input logic [7:0] base);
        logic timed_out;
        int   g;
        @(posedge clk); #1;
        rows = r; cols = c; CHNL_RX_LEN = len; CHNL_RX = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            repeat (gap) begin @(posedge clk); #1; end
            for (int i = 0; i < LANES; i++) CHNL_RX_DATA[i*AW +: AW] = 8'(base + b * LANES + i);
            CHNL_RX_DATA_VALID = 1'b1;
            timed_out = 1'b1;
            for (g = 0; g < 50; g++) begin
                @(negedge clk);
                if (CHNL_RX_DATA_REN) begin timed_out = 1'b0; break; end
            end
            check("ren_wait", timed_out, 0);
            @(posedge clk); #1;
            CHNL_RX_DATA_VALID = 1'b0;
        end
        CHNL_RX = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int limit);
        int k = 0;
        while (beat_q.size() < n && k < limit) begin @(negedge clk); k++; end
        repeat (6) @(negedge clk);
        check("beat_count", beat_q.size(), n);
        check("idle_tvalid", M_AXIS_TVALID, 0);
    endtask

    task automatic verify_frame(input string tag, input int c, input int n, input logic [7:0] base);
        logic [9:0] exp;
        for (int k = 0; k < n && k < beat_q.size(); k++) begin
            exp = {1'(k == 0), 1'((k % c) == (c - 1)), 8'(base + k)};
            check(tag, beat_q[k], exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {CHNL_RX_ACK, CHNL_RX_DATA_REN, M_AXIS_TVALID, M_AXIS_TUSER, M_AXIS_TLAST,
                    wea, enb, err, addra, addrb}, 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; rows = 0; cols = 0; CHNL_RX = 0; CHNL_RX_LAST = 0; CHNL_RX_LEN = 0;
        CHNL_RX_OFF = '0; CHNL_RX_DATA = '0; CHNL_RX_DATA_VALID = 0;
        clear_stats();
        #3;
        check_all_zero("reset_outputs");
        check("reset_keep", M_AXIS_TKEEP, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // A: 2x4 frame, always ready.
        clear_stats();
        send_frame(2, 4, A_LEN, 1, 0, 8'h00);
        wait_beats(8, 100);
        check("A_ack_cycles", ack_cycles, 1);
        check("A_wea_cnt", wea_cnt, 1);
        verify_frame("A_beat", 4, 8, 8'h00);
        if (beat_cyc.size() == 8) check("A_back_to_back", beat_cyc[7] - beat_cyc[0], 7);
        check("A_first_latency", first_tv_cyc - last_cons_cyc, 3);
        check("A_ren_low", CHNL_RX_DATA_REN, 0);

        // B: same frame under a stalling TREADY pattern.
        clear_stats();
        tready_mode = 1'b1;
        send_frame(2, 4, A_LEN, 1, 0, 8'h00);
        wait_beats(8, 200);
        verify_frame("B_beat", 4, 8, 8'h00);
        check("B_stalls_seen", stall_cnt != 0, 1);
        tready_mode = 1'b0;

        // C: 4x8 frame, two wide words with 3-cycle valid gaps.
        clear_stats();
        send_frame(4, 8, 8, 2, 3, 8'h00);
        wait_beats(32, 200);
        check("C_wea_cnt", wea_cnt, 2);
        if (wea_addr.size() == 2) begin
            check("C_wea_addr0", wea_addr[0], 0);
            check("C_wea_addr1", wea_addr[1], 1);
        end
        verify_frame("C_beat", 8, 32, 8'h00);

        // D: zero rows -> data consumed, no beats.
        clear_stats();
        send_frame(0, 16, 4, 1, 0, 8'hA0);
        wait_beats(0, 10);
        check("D_ren_cnt", ren_cnt, 1);
        check("D_ren_low", CHNL_RX_DATA_REN, 0);

        // E: reset after pixel 3, then a fresh frame.
        clear_stats();
        send_frame(2, 4, A_LEN, 1, 0, 8'h40);
        k = 0;
        while (beat_q.size() < 4 && k < 100) begin @(negedge clk); k++; end
        check("E_reached_pixel3", beat_q.size() >= 4, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check_all_zero("E_reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
        send_frame(2, 4, A_LEN, 1, 0, 8'h00);
        wait_beats(8, 100);
        verify_frame("E_beat", 4, 8, 8'h00);

`ifdef R2A_LEN_CHECK_EN
        // F: wrong length -> err, no beats; a correct frame still streams.
        clear_stats();
        check("F_err_clear", err, 0);
        send_frame(2, 4, 8, 2, 0, 8'h00);
        wait_beats(0, 10);
        check("F_err_set", err, 1);
        check("F_ren_cnt", ren_cnt, 2);
        clear_stats();
        send_frame(2, 4, 2, 1, 0, 8'h00);
        wait_beats(8, 100);
        verify_frame("F_beat", 4, 8, 8'h00);
        check("F_err_sticky", err, 1);
`else
        check("err_tied_low", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always reaches its summary.
    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riffa_rx_to_axis.md
Name: riffa_rx_to_axis

Overview:
- Host-to-fabric image path: accepts one RIFFA RX channel transfer per frame and buffers it in an external asymmetric BRAM.
- BRAM write port is PCIE_DATA_WIDTH wide; read port is AXIS_DATA_WIDTH wide.
- Replays the buffered frame as an AXI4-Stream video master: TUSER marks start of frame, TLAST marks end of line.
- Feeds HLS image cores (e.g. rotate) from host memory.

Parameters:
- PCIE_DATA_WIDTH, 128: RIFFA data width in bits; multiple of 32.
- AXIS_DATA_WIDTH, 8: pixel width in bits; divides PCIE_DATA_WIDTH.
- PCIE_ADDR_WIDTH, 12: BRAM write-port (wide word) address width.
- AXIS_ADDR_WIDTH, 16: BRAM read-port (pixel) address width.

Ports:
- clk  in  1  clock; also drives clka and clkb.
- rst_n  in  1  asynchronous active-low reset.
- rows  in  32  frame height in lines; sampled at ACK.
- cols  in  32  frame width in pixels; sampled at ACK.
- CHNL_RX  in  1  RIFFA transfer request.
- CHNL_RX_ACK  out  1  transfer acknowledge.
- CHNL_RX_LAST  in  1  ignored.
- CHNL_RX_LEN  in  32  transfer length in 32-bit words.
- CHNL_RX_OFF  in  31  ignored.
- CHNL_RX_DATA  in  PCIE_DATA_WIDTH  RX data.
- CHNL_RX_DATA_VALID  in  1  RX data valid.
- CHNL_RX_DATA_REN  out  1  RX data read-enable.
- M_AXIS_TDATA  out  AXIS_DATA_WIDTH  pixel.
- M_AXIS_TVALID  out  1  pixel valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TUSER  out  1  start of frame.
- M_AXIS_TLAST  out  1  end of line.
- M_AXIS_TKEEP, M_AXIS_TSTRB  out  AXIS_DATA_WIDTH/8  all ones.
- addra  out  PCIE_ADDR_WIDTH  BRAM write address.
- clka  out  1  = clk.
- dina  out  PCIE_DATA_WIDTH  = CHNL_RX_DATA.
- wea  out  1  BRAM write enable.
- addrb  out  AXIS_ADDR_WIDTH  BRAM read address.
- clkb  out  1  = clk.
- doutb  in  AXIS_DATA_WIDTH  BRAM read data; 1-cycle read latency.
- enb  out  1  BRAM read enable.
- err  out  1  sticky length error (see Optional Feature).

Behaviour:
- Reset values: all registered outputs 0 (ACK, REN, TVALID, TUSER, TLAST, addra, addrb, enb, wea, err); state IDLE; all counters 0.
- FSM states and transitions:
  - IDLE: when CHNL_RX=1, latch len=CHNL_RX_LEN, rows, cols, and npix=rows*cols (32-bit product, truncated) -> ACK.
  - ACK: CHNL_RX_ACK=1 for exactly one cycle -> RX.
  - RX: CHNL_RX_DATA_REN=1.
    - wea = VALID & REN; each write increments addra and adds PCIE_DATA_WIDTH/32 to wcnt.
    - Exit to TX when wcnt >= len, or when CHNL_RX=0 with VALID=0.
  - TX: stream npix pixels in order; -> IDLE after the last beat handshakes. npix=0 -> IDLE directly, no beats.
- Packing: pixel k sits in lane (k mod PCIE_DATA_WIDTH/AXIS_DATA_WIDTH) of wide word k/(PCIE_DATA_WIDTH/AXIS_DATA_WIDTH). Lane 0 is bits [AXIS_DATA_WIDTH-1:0]. Read address = k.
- AXIS rules:
  - TVALID holds until TREADY; TDATA, TUSER and TLAST are stable while TVALID=1 & TREADY=0.
  - Column/row counters advance only on TVALID&TREADY.
  - TUSER=1 only on pixel 0. TLAST=1 when col==cols-1.
- Read pipeline: enb issues a prefetch only when the skid buffer has a free slot. Sustains 1 pixel/cycle with TREADY=1, with first TVALID 2 cycles after entering TX. No beat duplicated or dropped under any TREADY pattern.
- Boundary conditions:
  - addra reaching 2^PCIE_ADDR_WIDTH-1: further words are still consumed (REN=1) but not written; addra saturates.
  - Fewer words received than npix requires: stale BRAM contents are streamed, no stall.
  - CHNL_RX asserted while in TX: ignored until IDLE.
  - Reset mid-operation: immediate return to IDLE; any partial frame is abandoned.
  - addra is zeroed on entry to RX; addrb is zeroed on entry to TX.

Optional Feature:
- Macro R2A_LEN_CHECK_EN.
- Defined: at ACK, compute need=ceil(npix*AXIS_DATA_WIDTH/32).
  - If CHNL_RX_LEN != need: set err=1 (sticky until reset). RX data is still consumed, TX is skipped, return to IDLE.
- Undefined: err tied 0; frame streams regardless of length.

Decomposition:
- Package riffa_axis_pkg holds:
  - state encoding IDLE/ACK/RX/TX;
  - constant PIX_PER_WORD = PCIE_DATA_WIDTH/AXIS_DATA_WIDTH;
  - constant WORDS32_PER_BEAT = PCIE_DATA_WIDTH/32.
- One sub-module, bram_axis_skid: 2-entry skid buffer turning the 1-latency BRAM read port plus prefetch credit into a registered AXIS source.

Test Plan:
- rows=2, cols=4, LEN=4, one beat carrying bytes 0x00..0x0F, TREADY=1 -> ACK exactly 1 cycle; pixels 0x00..0x07; TUSER on 0x00; TLAST on 0x03 and 0x07; back to IDLE.
- Same frame, TREADY pattern 1,0,0,1,0,1... -> identical 8-beat sequence; TDATA stable while stalled.
- rows=4, cols=8, LEN=8, DATA_VALID gaps of 3 cycles -> wea pulses exactly 2 times at addra 0 and 1; 32 pixels 0x00..0x1F.
- rows=0, cols=16, LEN=4 -> data consumed, zero AXIS beats, IDLE.
- R2A_LEN_CHECK_EN defined, rows=2, cols=4, LEN=8 -> err=1, no AXIS beats; next correct frame still consumes and streams, err stays 1.
- Reset asserted after pixel 3 of an 8-pixel frame -> all outputs 0; a new frame streams correctly from pixel 0 with TUSER.
